// File: rtl/chord_voice_scheduler.sv
// Three-voice note scheduler: assigns note events to free (or least-busy) voices,
// tracks per-voice remaining beats and stalls the song reader on wait events.
module chord_voice_scheduler #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic              beat,
   input  logic              event_valid,
   input  logic              event_is_wait,
   input  logic [NOTE_W-1:0] event_note,
   input  logic [DUR_W-1:0]  event_duration,
   output logic              event_ready,
   output logic [2:0]        voice_load,
   output logic [NOTE_W-1:0] voice_note,
   output logic [DUR_W-1:0]  voice_duration,
   output logic [2:0]        voice_active,
   output logic              voice_stolen
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t           state, state_nxt;
   logic [DUR_W-1:0] rem [3];
   logic [DUR_W-1:0] wait_cnt;

   logic             tick;
   logic             handshake;
   logic             note_ok;
   logic             wait_ok;
   logic [1:0]       sel;
   logic [DUR_W-1:0] min_rem;
   logic             steal;
   logic [2:0]       sel_onehot;

   function automatic logic [DUR_W-1:0] dec_sat(input logic [DUR_W-1:0] v);
      return (v == '0) ? v : v - DUR_W'(1);
   endfunction

   assign tick        = beat & play_enable;
   assign event_ready = (state == IDLE) & play_enable;
   assign handshake   = event_valid & event_ready;
   assign note_ok     = handshake & ~event_is_wait & (event_note != '0) & (event_duration != '0);
   assign wait_ok     = handshake & event_is_wait & (event_duration != '0);

   // Smallest remaining count wins, ties to the lowest index; a free voice has rem 0,
   // so it is always preferred and only a nonzero minimum means a steal.
   always_comb begin
      sel     = 2'd0;
      min_rem = rem[0];
      for (int i = 1; i < 3; i++) begin
         if (rem[i] < min_rem) begin
            min_rem = rem[i];
            sel     = 2'(i);
         end
      end
   end

   assign steal      = (min_rem != '0);
   assign sel_onehot = 3'b001 << sel;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         voice_active[i] = (rem[i] != '0);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (note_ok) state_nxt = ISSUE;
                  else if (wait_ok) state_nxt = WAIT;
         ISSUE:   state_nxt = IDLE;
         WAIT:    if (tick && wait_cnt == DUR_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake edge registers the strobe; the ISSUE cycle then commits rem[sel].
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         wait_cnt       <= '0;
         voice_load     <= '0;
         voice_note     <= '0;
         voice_duration <= '0;
         voice_stolen   <= 1'b0;
         for (int i = 0; i < 3; i++) rem[i] <= '0;
      end else begin
         state          <= state_nxt;
         voice_load     <= note_ok ? sel_onehot : 3'b000;
         voice_note     <= note_ok ? event_note : '0;
         voice_duration <= note_ok ? event_duration : '0;
         voice_stolen   <= note_ok & steal;

         if (wait_ok)
            wait_cnt <= event_duration;
         else if (state == WAIT && tick)
            wait_cnt <= wait_cnt - DUR_W'(1);

         for (int i = 0; i < 3; i++) begin
            if (state == ISSUE && voice_load[i])
               rem[i] <= voice_duration;
            else if (tick)
               rem[i] <= dec_sat(rem[i]);
         end
      end
   end

endmodule
